// File: rtl/aibcr3pnr_rstseq_pkg.sv
// rtl/aibcr3pnr_rstseq_pkg.sv - state encoding and sizing helpers for the staged reset sequencer
package aibcr3pnr_rstseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } rstseq_state_t;

  function automatic int cnt_width(input int settle, input int timeout);
    int m;
    m = (settle > timeout) ? settle : timeout;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aibcr3pnr_rstseq_cnt.sv
// rtl/aibcr3pnr_rstseq_cnt.sv - saturating up-counter with clear and terminal compare
module aibcr3pnr_rstseq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         hit
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/aibcr3pnr_rstseq.sv
// rtl/aibcr3pnr_rstseq.sv - staged reset-release sequencer with per-stage ack timeout
module aibcr3pnr_rstseq
  import aibcr3pnr_rstseq_pkg::*;
#(
  parameter int NUM_STAGES    = 3,
  parameter int STABLE_CYCLES = 16,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                scan_mode_n,
  input  logic                                rst_n_bypass,
  input  logic                                enable,
  input  logic [NUM_STAGES-1:0]               stage_ack,
  output logic [NUM_STAGES-1:0]               stage_rst_n,
  output logic                                seq_done,
  output logic                                seq_err,
  output logic [idx_width(NUM_STAGES)-1:0]    err_stage
);

  localparam int CW = cnt_width(STABLE_CYCLES, ACK_TIMEOUT);
  localparam int IW = idx_width(NUM_STAGES);
  localparam logic [CW-1:0] SETTLE_TERM = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ACK_TERM    = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_STAGES - 1);

  rstseq_state_t           state;
  logic [IW-1:0]           idx;
  logic [NUM_STAGES-1:0]   stage_rst_q;
  logic [CW-1:0]           cnt;
  logic                    cnt_hit;
  logic                    cnt_clr;
  logic [CW-1:0]           cnt_term;
  logic                    ack_cur;
  logic                    timeout;

  assign ack_cur  = stage_ack[idx];
  assign cnt_term = (state == ST_WAIT_ACK) ? ACK_TERM : SETTLE_TERM;
  assign timeout  = (ACK_TIMEOUT != 0) && cnt_hit;

  // One counter serves both phases; it restarts whenever a phase is entered.
  assign cnt_clr = !((state == ST_SETTLE) || (state == ST_WAIT_ACK)) ||
                   ((state == ST_WAIT_ACK) && ack_cur);

  aibcr3pnr_rstseq_cnt #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (1'b1),
    .term  (cnt_term),
    .count (cnt),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      stage_rst_q <= '0;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
      err_stage   <= '0;
    end else if ((state != ST_IDLE) && !enable) begin
      state       <= ST_IDLE;
      idx         <= '0;
      stage_rst_q <= '0;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_hit) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          stage_rst_q[idx] <= 1'b1;
          state            <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // A late ack still beats the timeout on the same edge.
          if (ack_cur) begin
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SETTLE;
            end
          end else if (timeout) begin
            state       <= ST_ERROR;
            stage_rst_q <= '0;
            seq_err     <= 1'b1;
            err_stage   <= idx;
          end
        end
        ST_DONE: begin
          seq_done <= 1'b1;
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stage_rst_n = scan_mode_n ? stage_rst_q : {NUM_STAGES{rst_n_bypass}};

endmodule

// File: tb/tb_aibcr3pnr_rstseq.sv
// tb/tb_aibcr3pnr_rstseq.sv - scoreboard bench for the staged reset sequencer
module tb_aibcr3pnr_rstseq;

  localparam int N = 3;
  localparam int S = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         scan_mode_n;
  logic         rst_n_bypass;
  logic         enable;
  logic [N-1:0] stage_ack;
  logic [N-1:0] stage_rst_n;
  logic         seq_done;
  logic         seq_err;
  logic [1:0]   err_stage;

  aibcr3pnr_rstseq #(.NUM_STAGES(N), .STABLE_CYCLES(S), .ACK_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_mode_n  (scan_mode_n),
    .rst_n_bypass (rst_n_bypass),
    .enable       (enable),
    .stage_ack    (stage_ack),
    .stage_rst_n  (stage_rst_n),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .err_stage    (err_stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] rn;
    logic       done;
    logic       err;
    logic [1:0] es;
    logic       chk_es;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   e0;
  int   e1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input int cyc, input string tag, input logic [2:0] rn, input logic done,
                      input logic err, input logic [1:0] es, input logic chk_es);
    exp_t x;
    x.cyc = cyc; x.tag = tag; x.rn = rn; x.done = done; x.err = err; x.es = es; x.chk_es = chk_es;
    sb.push_back(x);
  endtask

  task automatic check_due();
    exp_t x;
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      x = sb.pop_front();
      check(x.tag,
            {25'd0, (x.chk_es ? err_stage : 2'b00), seq_err, seq_done, stage_rst_n},
            {25'd0, (x.chk_es ? x.es : 2'b00), x.err, x.done, x.rn});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check_due();
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic start();
    enable = 1'b1;
    e0 = edge_n + 1;
  endtask

  task automatic finish_scn();
    enable = 1'b0;
    stage_ack = '0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sequence did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; scan_mode_n = 1'b1; rst_n_bypass = 1'b0; enable = 1'b0; stage_ack = '0;
    @(negedge clk);
    tick();
    push(edge_n + 1, "reset", 3'b000, 1'b0, 1'b0, 2'd0, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // normal three-stage release
    start();
    push(e0 + 4,  "s1_pre0", 3'b000, 0, 0, 2'd0, 1);
    push(e0 + 5,  "s1_rel0", 3'b001, 0, 0, 2'd0, 1);
    push(e0 + 11, "s1_pre1", 3'b001, 0, 0, 2'd0, 1);
    push(e0 + 12, "s1_rel1", 3'b011, 0, 0, 2'd0, 1);
    push(e0 + 18, "s1_pre2", 3'b011, 0, 0, 2'd0, 1);
    push(e0 + 19, "s1_rel2", 3'b111, 0, 0, 2'd0, 1);
    push(e0 + 21, "s1_ack2", 3'b111, 0, 0, 2'd0, 1);
    push(e0 + 22, "s1_done", 3'b111, 1, 0, 2'd0, 1);
    push(e0 + 25, "s1_hold", 3'b111, 1, 0, 2'd0, 1);
    run_to(e0 + 6);  stage_ack[0] = 1'b1;
    run_to(e0 + 13); stage_ack[1] = 1'b1;
    run_to(e0 + 20); stage_ack[2] = 1'b1;
    run_to(e0 + 25);
    enable = 1'b0;
    push(edge_n + 1, "s1_drop", 3'b000, 0, 0, 2'd0, 1);
    tick();
    finish_scn();

    // stage 1 never acks
    start();
    push(e0 + 5,  "s2_rel0",   3'b001, 0, 0, 2'd0, 1);
    push(e0 + 12, "s2_rel1",   3'b011, 0, 0, 2'd0, 1);
    push(e0 + 19, "s2_pre_to", 3'b011, 0, 0, 2'd0, 1);
    push(e0 + 20, "s2_err",    3'b000, 0, 1, 2'd1, 1);
    push(e0 + 22, "s2_hold",   3'b000, 0, 1, 2'd1, 1);
    run_to(e0 + 6); stage_ack[0] = 1'b1;
    run_to(e0 + 22);
    enable = 1'b0;
    push(edge_n + 1, "s2_clr", 3'b000, 0, 0, 2'd0, 0);
    tick();
    finish_scn();

    // ack arrives on the timeout edge of stage 0
    start();
    push(e0 + 5,  "s3_rel0",   3'b001, 0, 0, 2'd0, 0);
    push(e0 + 12, "s3_pre",    3'b001, 0, 0, 2'd0, 0);
    push(e0 + 13, "s3_tie",    3'b001, 0, 0, 2'd0, 0);
    push(e0 + 17, "s3_settle", 3'b001, 0, 0, 2'd0, 0);
    push(e0 + 18, "s3_rel1",   3'b011, 0, 0, 2'd0, 0);
    push(e0 + 21, "s3_noerr",  3'b011, 0, 0, 2'd0, 0);
    run_to(e0 + 12); stage_ack[0] = 1'b1;
    run_to(e0 + 21);
    finish_scn();

    // enable drop mid-settle of stage 2, then rst mid-wait-ack
    start();
    push(e0 + 12, "s4_rel1",    3'b011, 0, 0, 2'd0, 0);
    push(e0 + 15, "s4_settle2", 3'b011, 0, 0, 2'd0, 0);
    push(e0 + 16, "s4_drop",    3'b000, 0, 0, 2'd0, 0);
    run_to(e0 + 6);  stage_ack[0] = 1'b1;
    run_to(e0 + 13); stage_ack[1] = 1'b1;
    run_to(e0 + 15);
    enable = 1'b0; stage_ack = '0;
    run_to(e0 + 17);
    start();
    e1 = e0;
    push(e1 + 4, "s4_re_pre", 3'b000, 0, 0, 2'd0, 0);
    push(e1 + 5, "s4_re_rel", 3'b001, 0, 0, 2'd0, 0);
    push(e1 + 7, "s4_rst",    3'b000, 0, 0, 2'd0, 1);
    run_to(e1 + 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(e1 + 12, "s4_post_pre", 3'b000, 0, 0, 2'd0, 1);
    push(e1 + 13, "s4_restart",  3'b001, 0, 0, 2'd0, 1);
    run_to(e1 + 13);
    finish_scn();

    // stage_ack[2] high throughout, plus scan bypass while stage 2 settles
    stage_ack = 3'b100;
    tick();
    start();
    push(e0 + 5,  "s5_rel0",   3'b001, 0, 0, 2'd0, 1);
    push(e0 + 11, "s5_noskip", 3'b001, 0, 0, 2'd0, 1);
    push(e0 + 12, "s5_rel1",   3'b011, 0, 0, 2'd0, 1);
    push(e0 + 18, "s5_pre2",   3'b011, 0, 0, 2'd0, 1);
    push(e0 + 19, "s5_rel2",   3'b111, 0, 0, 2'd0, 1);
    push(e0 + 20, "s5_ack2",   3'b111, 0, 0, 2'd0, 1);
    push(e0 + 21, "s5_done",   3'b111, 1, 0, 2'd0, 1);
    run_to(e0 + 6);  stage_ack[0] = 1'b1;
    run_to(e0 + 13); stage_ack[1] = 1'b1;
    run_to(e0 + 15);
    scan_mode_n = 1'b0; rst_n_bypass = 1'b1;
    #1 check("scan_hi", {29'd0, stage_rst_n}, 32'h7);
    rst_n_bypass = 1'b0;
    #1 check("scan_lo", {29'd0, stage_rst_n}, 32'h0);
    tick();
    tick();
    check("scan_hold", {29'd0, stage_rst_n}, 32'h0);
    rst_n_bypass = 1'b1;
    #1 check("scan_hi2", {29'd0, stage_rst_n}, 32'h7);
    scan_mode_n = 1'b1; rst_n_bypass = 1'b0;
    #1 check("scan_exit", {29'd0, stage_rst_n}, 32'h3);
    run_to(e0 + 21);
    finish_scn();

    check("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
